sr_latch_bank_sequencer: RTL

- Shares one bank of NBITS SR latch cells among NREQ requesters. Each request is either a set or a clear of one addressed cell.
- Drives each cell's s/r pair with the cell convention: s=1,r=0 sets q=1; s=0,r=1 clears q=0; s=1,r=1 holds.
- The unused code s=0,r=0 is never driven.
- Arbitration is round-robin. Each write pulse is held for PULSE_CYC cycles, then the cell's q is read back to confirm the write before the requester is acknowledged.

---
 rtl/sr_latch_bank_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sr_latch_bank_sequencer.sv
// Round-robin sequencer sharing one bank of SR latch cells among several requesters.
// Each granted request sets or clears one cell. The code is held for PULSE_CYC cycles,
// then one all-hold settle cycle follows. The cell's q is then compared with the requested
// value, and the requester gets an ack (match) or a nack (mismatch).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req             per-requester request level, held until ack/nack
//   req_op          per-requester op (1=set, 0=clear), sampled at grant
//   req_idx         per-requester cell index, IDXW bits each, sampled at grant
//   ack, nack       one-cycle completion / failure pulse to the granted requester
//   lat_s, lat_r    s/r lines to the latch cells (11 = hold, 10 = set, 01 = clear)
//   lat_q           q from the latch cells
//   busy            high whenever the sequencer is not idle
//   grant_id        current or most recent grant
//   err_cnt         saturating count of nack events
`timescale 1ns/1ps
module sr_latch_bank_sequencer #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned NBITS     = 8,
  parameter int unsigned IDXW      = (NBITS > 1) ? $clog2(NBITS) : 1,
  parameter int unsigned PULSE_CYC = 2,
  localparam int unsigned GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      nack,
  output logic [NBITS-1:0]     lat_s,
  output logic [NBITS-1:0]     lat_r,
  input  logic [NBITS-1:0]     lat_q,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  state_e            state_q;
  logic [GW-1:0]     ptr_q;
  logic              op_q;
  logic [IDXW-1:0]   idx_q;
  logic [3:0]        cnt_q;

  logic              found;
  logic [GW-1:0]     sel_id;
  logic              sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_in_range;
  logic [NBITS-1:0]  sel_mask;
  logic [NBITS-1:0]  cur_mask;
  logic [NREQ-1:0]   sel_oh;
  logic [NREQ-1:0]   gnt_oh;
  logic              q_sel;

  function automatic logic [GW-1:0] ptr_next(input logic [GW-1:0] id);
    return (32'(id) == NREQ - 1) ? '0 : id + GW'(1);
  endfunction

  // Round-robin pick: first pass takes requesters at or above the pointer,
  // second pass wraps around to the lower ones.
  always_comb begin
    found   = 1'b0;
    sel_id  = '0;
    sel_op  = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && req[k] && (GW'(k) >= ptr_q)) begin
        found   = 1'b1;
        sel_id  = GW'(k);
        sel_op  = req_op[k];
        sel_idx = req_idx[k*IDXW +: IDXW];
      end
    end
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        sel_id  = GW'(k);
        sel_op  = req_op[k];
        sel_idx = req_idx[k*IDXW +: IDXW];
      end
    end
  end

  always_comb begin
    sel_in_range = (32'(sel_idx) < NBITS);
    sel_mask     = '0;
    cur_mask     = '0;
    for (int k = 0; k < int'(NBITS); k++) begin
      sel_mask[k] = (sel_idx == IDXW'(k));
      cur_mask[k] = (idx_q == IDXW'(k));
    end
    sel_oh = '0;
    gnt_oh = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      sel_oh[k] = (sel_id == GW'(k));
      gnt_oh[k] = (grant_id == GW'(k));
    end
    q_sel = |(lat_q & cur_mask);
  end

  assign busy = (state_q != StIdle);

  // lat_s/lat_r are registers that reset to all ones, so a 00 code cannot appear.
  // Only the addressed bit ever leaves the hold code, and only one of its two lines drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      lat_s    <= '1;
      lat_r    <= '1;
      ack      <= '0;
      nack     <= '0;
      grant_id <= '0;
      err_cnt  <= '0;
    end else begin
      ack  <= '0;
      nack <= '0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_id <= sel_id;
            op_q     <= sel_op;
            idx_q    <= sel_idx;
            cnt_q    <= 4'(PULSE_CYC);
            if (sel_in_range) begin
              state_q <= StDrive;
              lat_s   <= sel_op ? '1 : ~sel_mask;
              lat_r   <= sel_op ? ~sel_mask : '1;
            end else begin
              // Bad index: refuse without touching the bank.
              nack  <= sel_oh;
              ptr_q <= ptr_next(sel_id);
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        StDrive: begin
          if (cnt_q == 4'd1) begin
            state_q <= StSettle;
            lat_s   <= '1;
            lat_r   <= '1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StSettle: state_q <= StCheck;
        StCheck: begin
          if (q_sel == op_q) begin
            ack <= gnt_oh;
          end else begin
            nack <= gnt_oh;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
          ptr_q   <= ptr_next(grant_id);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
